// File: rtl/led_pwm_pkg.sv
// Register map, bit positions and byte-merge helper shared by the led_pwm files.
package led_pwm_pkg;

   localparam int REG_CTRL      = 0;
   localparam int REG_OUT       = 1;
   localparam int REG_MODE      = 2;
   localparam int REG_PRESCALE  = 3;
   localparam int REG_STATUS    = 4;
   localparam int REG_DUTY_BASE = 8;

   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int STATUS_WRAP_BIT = 0;

   // Replace only the bytes whose enable is set; callers truncate to register width.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int k = 0; k < 4; k++) begin
         if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: pending/active duty pair and the registered PWM/direct output.
module led_pwm_channel
   import led_pwm_pkg::*;
#(
   parameter int PWM_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [PWM_W-1:0] wdat,
   input  logic             en,
   input  logic             wrap,
   input  logic             mode,
   input  logic             level,
   input  logic [PWM_W-1:0] cnt,
   output logic [PWM_W-1:0] pend,
   output logic             led
);

   logic [PWM_W-1:0] active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend   <= '0;
         active <= '0;
         led    <= 1'b0;
      end else begin
         if (wr) pend <= wdat;
         // NOTE: non-blocking, so on an edge where both update, active takes pend's pre-write value.
         if (wrap || !en) active <= pend;
         led <= mode ? (en & (active > cnt)) : level;
      end
   end

endmodule

// File: rtl/led_pwm.sv
// Multi-channel LED driver with shared prescaler/period counter and per-channel PWM duty.
// Optional LED_PWM_IRQ_EN adds CTRL.IRQ_EN and the o_irq output.
module led_pwm
   import led_pwm_pkg::*;
#(
   parameter int NUM_CH = 8,
   parameter int PWM_W  = 8,
   parameter int PRE_W  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_stb,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [3:0]        i_we,
   input  logic [31:0]       i_dat_w,
   output logic [31:0]       o_dat_r,
   output logic              o_ack,
   output logic [NUM_CH-1:0] o_led
`ifdef LED_PWM_IRQ_EN
   ,
   output logic              o_irq
`endif
);

`ifdef LED_PWM_IRQ_EN
   localparam int CTRL_W = 2;
`else
   localparam int CTRL_W = 1;
`endif

   logic                         access;
   logic                         wr_access;
   logic [CTRL_W-1:0]            ctrl_q;
   logic [NUM_CH-1:0]            out_q;
   logic [NUM_CH-1:0]            mode_q;
   logic [PRE_W-1:0]             prescale_q;
   logic [PRE_W-1:0]             pre_cnt;
   logic [PWM_W-1:0]             pwm_cnt;
   logic                         wrap_q;
   logic                         en;
   logic                         tick;
   logic                         wrap;
   logic                         wrap_clr;
   logic [NUM_CH-1:0][PWM_W-1:0] duty_pend;
   logic [NUM_CH-1:0]            duty_wr;
   logic [31:0]                  rd_val;

   function automatic logic hit(input logic [ADDR_W-1:0] a, input int idx);
      return a == ADDR_W'(idx);
   endfunction

   // A strobe is serviced on the edge that raises ack; the held strobe is ignored while ack is high.
   assign access    = i_stb & ~o_ack;
   assign wr_access = access & (|i_we);
   assign en        = ctrl_q[CTRL_EN_BIT];

   assign tick     = en && (pre_cnt >= prescale_q);
   assign wrap     = tick && (pwm_cnt == '1);
   assign wrap_clr = wr_access && hit(i_addr, REG_STATUS) && i_we[0] && i_dat_w[STATUS_WRAP_BIT];

   always_comb begin
      // NOTE: default first so every path assigns rd_val and no latch is inferred.
      rd_val = '0;
      if (hit(i_addr, REG_CTRL))          rd_val[CTRL_W-1:0]      = ctrl_q;
      else if (hit(i_addr, REG_OUT))      rd_val[NUM_CH-1:0]      = out_q;
      else if (hit(i_addr, REG_MODE))     rd_val[NUM_CH-1:0]      = mode_q;
      else if (hit(i_addr, REG_PRESCALE)) rd_val[PRE_W-1:0]       = prescale_q;
      else if (hit(i_addr, REG_STATUS))   rd_val[STATUS_WRAP_BIT] = wrap_q;
      for (int n = 0; n < NUM_CH; n++) begin
         if (hit(i_addr, REG_DUTY_BASE + n)) rd_val[PWM_W-1:0] = duty_pend[n];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ack      <= 1'b0;
         o_dat_r    <= '0;
         ctrl_q     <= '0;
         out_q      <= '0;
         mode_q     <= '0;
         prescale_q <= '0;
      end else begin
         o_ack   <= access;
         o_dat_r <= access ? rd_val : '0;
         if (wr_access) begin
            if (hit(i_addr, REG_CTRL))
               ctrl_q <= CTRL_W'(byte_merge(32'(ctrl_q), i_dat_w, i_we));
            if (hit(i_addr, REG_OUT))
               out_q <= NUM_CH'(byte_merge(32'(out_q), i_dat_w, i_we));
            if (hit(i_addr, REG_MODE))
               mode_q <= NUM_CH'(byte_merge(32'(mode_q), i_dat_w, i_we));
            if (hit(i_addr, REG_PRESCALE))
               prescale_q <= PRE_W'(byte_merge(32'(prescale_q), i_dat_w, i_we));
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
      end else if (!en) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
         pwm_cnt <= pwm_cnt + PWM_W'(1);
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   // Sticky wrap flag; a wrap on the same edge as a clear keeps it set.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)      wrap_q <= 1'b0;
      else if (wrap)     wrap_q <= 1'b1;
      else if (wrap_clr) wrap_q <= 1'b0;
   end

`ifdef LED_PWM_IRQ_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_irq <= 1'b0;
      else          o_irq <= wrap_q & ctrl_q[CTRL_IRQ_EN_BIT];
   end
`endif

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      assign duty_wr[n] = wr_access && hit(i_addr, REG_DUTY_BASE + n);

      led_pwm_channel #(
         .PWM_W (PWM_W)
      ) u_ch (
         .clk   (i_clk),
         .rst_n (i_rst_n),
         .wr    (duty_wr[n]),
         .wdat  (PWM_W'(byte_merge(32'(duty_pend[n]), i_dat_w, i_we))),
         .en    (en),
         .wrap  (wrap),
         .mode  (mode_q[n]),
         .level (out_q[n]),
         .cnt   (pwm_cnt),
         .pend  (duty_pend[n]),
         .led   (o_led[n])
      );
   end

endmodule

// File: tb/tb_led_pwm.sv
// Randomized self-checking bench for led_pwm against a register/duty-count reference model.
module tb_led_pwm;

   localparam int NUM_CH = 8;
   localparam int PWM_W  = 8;
   localparam int PRE_W  = 16;
   localparam int ADDR_W = 4;
`ifdef LED_PWM_IRQ_EN
   localparam logic [31:0] CTRL_MASK = 32'h3;
`else
   localparam logic [31:0] CTRL_MASK = 32'h1;
`endif

   logic              i_clk = 1'b0;
   logic              i_rst_n;
   logic              i_stb;
   logic [ADDR_W-1:0] i_addr;
   logic [3:0]        i_we;
   logic [31:0]       i_dat_w;
   logic [31:0]       o_dat_r;
   logic              o_ack;
   logic [NUM_CH-1:0] o_led;
`ifdef LED_PWM_IRQ_EN
   logic              o_irq;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [31:0] m_reg [16];

   led_pwm #(
      .NUM_CH (NUM_CH),
      .PWM_W  (PWM_W),
      .PRE_W  (PRE_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_stb   (i_stb),
      .i_addr  (i_addr),
      .i_we    (i_we),
      .i_dat_w (i_dat_w),
      .o_dat_r (o_dat_r),
      .o_ack   (o_ack),
      .o_led   (o_led)
`ifdef LED_PWM_IRQ_EN
      ,
      .o_irq   (o_irq)
`endif
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] reg_mask(input int a);
      if (a == 0)           return CTRL_MASK;
      if (a == 1 || a == 2) return 32'((1 << NUM_CH) - 1);
      if (a == 3)           return 32'((1 << PRE_W) - 1);
      if (a == 4)           return 32'h1;
      if (a >= 8 && a < 8 + NUM_CH) return 32'((1 << PWM_W) - 1);
      return 32'h0;
   endfunction

   task automatic model_write(input int a, input logic [3:0] we, input logic [31:0] dat);
      logic [31:0] bm;
      for (int k = 0; k < 4; k++) bm[8*k +: 8] = {8{we[k]}};
      m_reg[a] = ((m_reg[a] & ~bm) | (dat & bm)) & reg_mask(a);
   endtask

   task automatic model_reset();
      for (int a = 0; a < 16; a++) m_reg[a] = '0;
   endtask

   // Starts just after an edge; returns just after the edge following the ack.
   task automatic bus(input int a, input logic [3:0] we, input logic [31:0] dat,
                      output logic [31:0] rdat);
      i_stb   = 1'b1;
      i_addr  = ADDR_W'(a);
      i_we    = we;
      i_dat_w = dat;
      #1;
      check("ack_pre", 32'(o_ack), 32'd0);
      @(posedge i_clk); #1;
      check("ack_rise", 32'(o_ack), 32'd1);
      rdat  = o_dat_r;
      i_stb = 1'b0;
      i_we  = 4'b0;
      @(posedge i_clk); #1;
      check("ack_fall", 32'(o_ack), 32'd0);
      check("dat_idle", o_dat_r, 32'd0);
   endtask

   task automatic reg_write(input int a, input logic [3:0] we, input logic [31:0] dat);
      logic [31:0] r;
      bus(a, we, dat, r);
      model_write(a, we, dat);
   endtask

   task automatic reg_read(input string tag, input int a);
      logic [31:0] r;
      bus(a, 4'b0, 32'h0, r);
      check(tag, r, m_reg[a]);
   endtask

   task automatic wait_led0(input logic lvl, input int budget, output int at);
      at = -1;
      for (int k = 0; k < budget; k++) begin
         @(posedge i_clk); #1;
         if (o_led[0] === lvl) begin
            at = cyc;
            return;
         end
      end
      check("led0_wait", 32'(o_led[0]), 32'(lvl));
   endtask

   initial begin
      logic [31:0] r;
      int a, p, w, r0, f0, r1, f1, r2;
      int hi [NUM_CH];
      int exp_hi;

      i_rst_n = 1'b0;
      i_stb   = 1'b0;
      i_addr  = '0;
      i_we    = '0;
      i_dat_w = '0;
      model_reset();
      repeat (3) @(posedge i_clk);
      #1;
      check("rst_led", 32'(o_led), 32'd0);
      check("rst_ack", 32'(o_ack), 32'd0);
      check("rst_dat", o_dat_r, 32'd0);
      @(negedge i_clk) i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      // Direct mode with a single byte enable
      reg_write(1, 4'b0001, 32'hFFFF_FFA5);
      check("out_led", 32'(o_led), 32'h0000_00A5);
      reg_read("out_rd", 1);
      reg_read("mode_rd", 2);

      // Random register traffic with EN possibly toggling; STATUS left alone
      for (int i = 0; i < 40; i++) begin
         a = $urandom_range(0, 15);
         if (a == 4) a = 5;
         if ($urandom_range(0, 1) == 1)
            reg_write(a, 4'($urandom_range(1, 15)), $urandom);
         else
            reg_read("rnd_rd", a);
      end

      // Unmapped addresses are acked, read 0 and change nothing
      reg_read("unm5_rd", 5);
      reg_write(6, 4'hF, $urandom);
      for (int i = 0; i < 16; i++) begin
         if (i != 4) reg_read("after_unm", i);
      end

      // Duty over a full period equals the high-cycle count, per channel
      for (int it = 0; it < 3; it++) begin
         reg_write(0, 4'hF, 32'h0);
         reg_write(4, 4'h1, 32'h1);
         p = $urandom_range(0, 3);
         reg_write(3, 4'hF, 32'(p));
         reg_write(2, 4'h1, $urandom);
         reg_write(1, 4'h1, $urandom);
         for (int n = 0; n < NUM_CH; n++) reg_write(8 + n, 4'h1, $urandom);
         if (it == 0) begin
            reg_write(2, 4'h1, 32'hFF);
            reg_write(8, 4'h1, 32'h00);
            reg_write(9, 4'h1, 32'hFF);
         end
         reg_write(0, 4'h1, 32'h1);
         bus(4, 4'b0, 32'h0, r);
         check("wrap_early", r, 32'd0);
         w = 256 * (p + 1);
         for (int n = 0; n < NUM_CH; n++) hi[n] = 0;
         for (int c = 0; c < w; c++) begin
            @(posedge i_clk); #1;
            for (int n = 0; n < NUM_CH; n++) hi[n] += int'(o_led[n]);
         end
         for (int n = 0; n < NUM_CH; n++) begin
            if (m_reg[2][n]) exp_hi = int'(m_reg[8 + n][7:0]) * (p + 1);
            else             exp_hi = m_reg[1][n] ? w : 0;
            check($sformatf("duty_cnt_ch%0d", n), 32'(hi[n]), 32'(exp_hi));
         end
         bus(4, 4'b0, 32'h0, r);
         check("wrap_set", r, 32'd1);
         reg_write(4, 4'h1, 32'h1);
         bus(4, 4'b0, 32'h0, r);
         check("wrap_clr", r, 32'd0);
      end

      // Mid-period duty change takes effect only from the next period
      reg_write(0, 4'hF, 32'h0);
      reg_write(3, 4'hF, 32'h0);
      reg_write(2, 4'h1, 32'h01);
      reg_write(8, 4'h1, 32'd64);
      reg_write(0, 4'h1, 32'h1);
      wait_led0(1'b0, 600, f0);
      wait_led0(1'b1, 600, r0);
      wait_led0(1'b0, 600, f0);
      check("glitch_hi_old", 32'(f0 - r0), 32'd64);
      repeat (30) @(posedge i_clk);
      #1;
      reg_write(8, 4'h1, 32'd192);
      wait_led0(1'b1, 600, r1);
      check("glitch_period", 32'(r1 - r0), 32'd256);
      wait_led0(1'b0, 600, f1);
      check("glitch_hi_new", 32'(f1 - r1), 32'd192);
      wait_led0(1'b1, 600, r2);
      check("glitch_lo_new", 32'(r2 - f1), 32'd64);

      // Asynchronous reset during an acked read with PWM running
      reg_write(2, 4'h1, 32'h00);
      reg_write(1, 4'h1, 32'h3C);
      check("pre_rst_led", 32'(o_led), 32'h3C);
      i_stb  = 1'b1;
      i_addr = ADDR_W'(1);
      i_we   = 4'b0;
      @(posedge i_clk); #1;
      check("pre_rst_ack", 32'(o_ack), 32'd1);
      check("pre_rst_dat", o_dat_r, 32'h3C);
      #2 i_rst_n = 1'b0;
      #1;
      check("arst_led", 32'(o_led), 32'd0);
      check("arst_ack", 32'(o_ack), 32'd0);
      check("arst_dat", o_dat_r, 32'd0);
      @(posedge i_clk); #1;
      check("arst_no_ack", 32'(o_ack), 32'd0);
      i_stb = 1'b0;
      model_reset();
      @(negedge i_clk) i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      for (int i = 0; i < 16; i++) reg_read("post_rst_rd", i);

`ifdef LED_PWM_IRQ_EN
      check("irq_rst", 32'(o_irq), 32'd0);
      reg_write(3, 4'hF, 32'h0);
      reg_write(0, 4'h1, 32'h3);
      for (int k = 0; k < 400 && o_irq !== 1'b1; k++) begin
         @(posedge i_clk); #1;
      end
      check("irq_rise", 32'(o_irq), 32'd1);
      reg_write(4, 4'h1, 32'h1);
      check("irq_clr", 32'(o_irq), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
